gpio_bus_ctrl: RTL
==================

# gpio_bus_ctrl

I/O bus sequencer that sits directly upstream of the dev-board GPIO block. It turns single-cycle CPU I/O requests into the `RD_GPIO`/`WR_GPIO`/`ADDR_GPIO`/`GPO` strobes that block consumes. For reads it captures the registered `GPI` word it returns. It decodes a two-word GPIO window, rejects other addresses, and reports completion with a one-cycle ready pulse.

## Interface
Parameters:
- `GPIO_BASE`, 16'h0000: word address of the DIP-switch register. `GPIO_BASE+1` is the LED register.

Ports:
- `CLK`  in  1  system clock
- `RESET`  in  1  asynchronous reset, active high
- `IO_REQ`  in  1  request pulse; sampled only in IDLE
- `IO_WE`  in  1  1 = write, 0 = read; qualified by `IO_REQ`
- `IO_ADDR`  in  16  word address; qualified by `IO_REQ`
- `IO_WDATA`  in  16  write data; qualified by `IO_REQ`
- `IO_RDATA`  out  16  read data; valid while `IO_READY`=1, held afterwards
- `IO_READY`  out  1  one-cycle completion pulse
- `IO_ERR`  out  1  unmapped access; valid with `IO_READY`
- `IO_BUSY`  out  1  high in every state except IDLE
- `GPO`  out  16  write data to GPIO block
- `RD_GPIO`  out  1  read strobe to GPIO block
- `WR_GPIO`  out  1  write strobe to GPIO block
- `ADDR_GPIO`  out  1  register select: 0 = DIP switches, 1 = LEDs
- `GPI`  in  16  registered read word from GPIO block. It reflects the `ADDR_GPIO` value of the previous cycle.

## Operation
States are IDLE, SETUP, WAIT and DONE.
- **IDLE:** on `IO_REQ`=1, latch `IO_WE`, `IO_ADDR` and `IO_WDATA`, then decode:
  - `IO_ADDR`==`GPIO_BASE` gives sel=0.
  - `IO_ADDR`==`GPIO_BASE+1` gives sel=1. The `+1` wraps modulo 2^16.
  - Any other address sets the error flag and goes straight to DONE. No GPIO strobe is asserted.
  - A mapped address goes to SETUP.
- **SETUP:** drive `ADDR_GPIO`=sel for one cycle.
  - Read: `RD_GPIO`=1, next state WAIT.
  - Write with sel=1: `WR_GPIO`=1 and `GPO`=latched wdata, next state DONE. The GPIO block loads `GPO[7:0]` into the LEDs on this edge.
  - Write with sel=0: the DIP register is read-only. No `WR_GPIO` strobe, `GPO` unchanged, next state DONE, `IO_ERR`=0.
- **WAIT (reads only):** `ADDR_GPIO` held. `GPI` now holds the selected register. `IO_RDATA` <= `GPI` on this edge. Next state DONE.
- **DONE:** `IO_READY`=1 and `IO_ERR`=error flag for this cycle only. Next state IDLE.
  - Writes and errored reads drive `IO_RDATA`=16'h0000.
- Between transactions:
  - `ADDR_GPIO` holds its last driven value, so `GPI` keeps tracking the last selected register.
  - `GPO` holds the last value written.
- An `IO_REQ` arriving while `IO_BUSY`=1 is ignored: no queueing and no error. The requester must wait for `IO_READY`.
- `RD_GPIO` and `WR_GPIO` are never high together, and each is high for at most one cycle per transaction.

## Timing
- All outputs are registered, and all are updated on rising `CLK`.
- Reset values (all asynchronous):
  - State = IDLE.
  - `IO_RDATA`, `GPO` = 16'h0000.
  - `IO_READY`, `IO_ERR`, `IO_BUSY`, `RD_GPIO`, `WR_GPIO`, `ADDR_GPIO` = 0.
- Cycle numbering: cycle 0 is the cycle in which `IO_REQ` is sampled in IDLE.
- Mapped read: SETUP in cycle 1, WAIT in cycle 2, `IO_READY` in cycle 3 with data. Latency is 3.
- Write: SETUP in cycle 1, `IO_READY` in cycle 2. Latency is 2.
- Unmapped access: `IO_READY` and `IO_ERR` in cycle 1. Latency is 1.
- Back-to-back issue: the earliest next accepted `IO_REQ` is the cycle after `IO_READY`. Sustained rates are 1 read per 4 cycles and 1 write per 3 cycles.
- Reset asserted mid-transaction:
  - Immediate return to IDLE. Strobes drop asynchronously. No `IO_READY` is issued.
  - Any LED write already strobed before the reset still counts.
  - After release, the first `IO_REQ` is accepted normally.

## Test plan
- **Reset:** assert `RESET` mid-operation -> all outputs 0 immediately. Release `RESET`, then issue a write of 16'h00A5 to `GPIO_BASE+1` -> `WR_GPIO` high in cycle 1, `GPO`=16'h00A5, `IO_READY` in cycle 2, `IO_ERR`=0.
- **Read the switches:** DIP switches = 4'b1010, read `GPIO_BASE`. The previous `ADDR_GPIO` is 1, so the stale `GPI` holds the LED word. Required: `IO_RDATA`=16'h000A at `IO_READY` in cycle 3, and the stale LED word is not returned.
- **Read back the LEDs:** write 16'h1234 to `GPIO_BASE+1`, then read it -> `IO_RDATA`=16'h0034, `IO_READY` 3 cycles after the read request.
- **Errors:** read `GPIO_BASE+2` -> `IO_READY` and `IO_ERR` in cycle 1, `IO_RDATA`=0, no `RD_GPIO`. Write to `GPIO_BASE` -> no `WR_GPIO`, `IO_ERR`=0, LEDs unchanged.
- **Busy drop:** issue a read, then pulse `IO_REQ` again in cycles 1 and 2 -> exactly one `IO_READY`, and the second request is lost. Issue a new request in the cycle after `IO_READY` -> accepted.
- **Reset mid-read:** assert `RESET` during WAIT -> `IO_READY` never pulses, state is IDLE, `ADDR_GPIO`=0. The next read completes in 3 cycles.

Source files
------------

// File: rtl/gpio_bus_ctrl.sv
// gpio_bus_ctrl
// -------------
// Sequencer between the CPU I/O request port and the dev-board GPIO block.
// A single-cycle request is turned into one GPIO read or write strobe,
// the registered GPI word is captured for reads, and completion is
// reported with a one-cycle IO_READY pulse. Two word addresses are mapped:
// GPIO_BASE (DIP switches, read-only) and GPIO_BASE+1 (LEDs). Any other
// address completes immediately with IO_ERR.
//
// Ports
//   CLK        in   system clock
//   RESET      in   asynchronous reset, active high
//   IO_REQ     in   request pulse, sampled only when idle
//   IO_WE      in   1 = write, 0 = read
//   IO_ADDR    in   [15:0] word address
//   IO_WDATA   in   [15:0] write data
//   IO_RDATA   out  [15:0] read data, valid with IO_READY, held afterwards
//   IO_READY   out  one-cycle completion pulse
//   IO_ERR     out  unmapped access, valid with IO_READY
//   IO_BUSY    out  high whenever a transaction is in progress
//   GPO        out  [15:0] write data to the GPIO block
//   RD_GPIO    out  read strobe to the GPIO block
//   WR_GPIO    out  write strobe to the GPIO block
//   ADDR_GPIO  out  register select, 0 = DIP switches, 1 = LEDs
//   GPI        in   [15:0] registered read word, follows ADDR_GPIO one cycle late
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for IO_REQ
// ST_SETUP | ADDR_GPIO driven, RD_GPIO or WR_GPIO strobe high
// ST_WAIT  | read only: GPI now reflects the selected register
// ST_DONE  | IO_READY (and IO_ERR for unmapped addresses) high

module gpio_bus_ctrl #(
  parameter logic [15:0] GPIO_BASE = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IO_REQ,
  input  logic        IO_WE,
  input  logic [15:0] IO_ADDR,
  input  logic [15:0] IO_WDATA,
  output logic [15:0] IO_RDATA,
  output logic        IO_READY,
  output logic        IO_ERR,
  output logic        IO_BUSY,
  output logic [15:0] GPO,
  output logic        RD_GPIO,
  output logic        WR_GPIO,
  output logic        ADDR_GPIO,
  input  logic [15:0] GPI
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;
  logic   we_q;

  // 16-bit sum so GPIO_BASE = 16'hFFFF maps the LED register to 16'h0000.
  logic [15:0] led_addr;
  logic        hit_dip;
  logic        hit_led;

  assign led_addr = GPIO_BASE + 16'd1;
  assign hit_dip  = (IO_ADDR == GPIO_BASE);
  assign hit_led  = (IO_ADDR == led_addr);

  // Outputs are registered from the state being entered, so the strobes of
  // SETUP are loaded on the edge that leaves IDLE, and so on.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      IO_RDATA  <= 16'h0000;
      IO_READY  <= 1'b0;
      IO_ERR    <= 1'b0;
      IO_BUSY   <= 1'b0;
      GPO       <= 16'h0000;
      RD_GPIO   <= 1'b0;
      WR_GPIO   <= 1'b0;
      ADDR_GPIO <= 1'b0;
    end else begin
      // Pulses default low; ADDR_GPIO, GPO and IO_RDATA hold.
      IO_READY <= 1'b0;
      IO_ERR   <= 1'b0;
      RD_GPIO  <= 1'b0;
      WR_GPIO  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (IO_REQ) begin
            we_q    <= IO_WE;
            IO_BUSY <= 1'b1;
            if (hit_dip || hit_led) begin
              state     <= ST_SETUP;
              ADDR_GPIO <= hit_led;
              RD_GPIO   <= ~IO_WE;
              // DIP register is read-only: a write to it strobes nothing.
              if (IO_WE && hit_led) begin
                WR_GPIO <= 1'b1;
                GPO     <= IO_WDATA;
              end
            end else begin
              state    <= ST_DONE;
              IO_READY <= 1'b1;
              IO_ERR   <= 1'b1;
              IO_RDATA <= 16'h0000;
            end
          end
        end

        ST_SETUP: begin
          if (we_q) begin
            state    <= ST_DONE;
            IO_READY <= 1'b1;
            IO_RDATA <= 16'h0000;
          end else begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // GPI was reloaded on the SETUP edge with the newly selected register.
          state    <= ST_DONE;
          IO_RDATA <= GPI;
          IO_READY <= 1'b1;
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          IO_BUSY <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          IO_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
